// File: rtl/mul_seq_ctrl_pkg.sv
// Shared encodings and defaults for the repeated-addition multiplier control path.
package mul_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LDA  = 3'd1;
    localparam logic [2:0] S_LDB  = 3'd2;
    localparam logic [2:0] S_ADD  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int MAX_ITER_DEF = 65535;
    localparam int IW_DEF       = 16;

    // Strobe bundle decoded from state each cycle.
    typedef struct packed {
        logic ld_a;
        logic ld_b;
        logic dec_b;
        logic clr_p;
        logic ld_p;
        logic busy;
        logic done;
    } strobe_t;

    localparam strobe_t STROBE_IDLE = '0;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Host handshake plus datapath strobes between the multiplier controller and its datapath.
interface mul_seq_ctrl_if;
    logic start;
    logic eqz;
    logic ld_a;
    logic ld_b;
    logic dec_b;
    logic clr_p;
    logic ld_p;
    logic busy;
    logic done;
    logic err;

    // Host/datapath side.
    modport master (
        output start, eqz,
        input  ld_a, ld_b, dec_b, clr_p, ld_p, busy, done, err
    );

    // Controller side.
    modport slave (
        input  start, eqz,
        output ld_a, ld_b, dec_b, clr_p, ld_p, busy, done, err
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Control FSM for P = A added B times, with an iteration watchdog on oversized B.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int IW       = IW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_seq_ctrl_if.slave  bus
);

    localparam logic [IW-1:0] CNT_MAX = IW'(MAX_ITER);

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    strobe_t       st;

    // Strobes decode straight from state so reset clears them without waiting for an edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        st      = STROBE_IDLE;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LDA;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_LDA: begin
                st.ld_a = 1'b1;
                st.busy = 1'b1;
                state_d = S_LDB;
            end
            S_LDB: begin
                st.ld_b  = 1'b1;
                st.clr_p = 1'b1;
                st.busy  = 1'b1;
                state_d  = S_ADD;
            end
            S_ADD: begin
                st.busy = 1'b1;
                if (bus.eqz) begin
                    state_d = S_DONE;
                end else if (cnt_q < CNT_MAX) begin
                    st.ld_p  = 1'b1;
                    st.dec_b = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end else begin
                    // Runaway B: abort before the counter could wrap.
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                st.done = 1'b1;
                if (!bus.start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.ld_a  = st.ld_a;
    assign bus.ld_b  = st.ld_b;
    assign bus.dec_b = st.dec_b;
    assign bus.clr_p = st.clr_p;
    assign bus.ld_p  = st.ld_p;
    assign bus.busy  = st.busy;
    assign bus.done  = st.done;
    assign bus.err   = err_q;

endmodule
